// File: rtl/m_wb_ledpwm_pkg.sv
// rtl/m_wb_ledpwm_pkg.sv - register indices and byte-lane mask helper for the LED PWM slave
package m_wb_ledpwm_pkg;

   localparam logic [1:0] A_OUT      = 2'd0;
   localparam logic [1:0] A_PWMEN    = 2'd1;
   localparam logic [1:0] A_DUTY     = 2'd2;
   localparam logic [1:0] A_PRESCALE = 2'd3;

   // Expand SEL into a 32-bit write mask limited to the bits a register implements.
   function automatic logic [31:0] sel_mask(input logic [3:0] sel, input int unsigned width);
      logic [31:0] lanes;
      logic [31:0] lim;
      lanes = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
      lim   = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return lanes & lim;
   endfunction

endpackage

// File: rtl/m_wb_ledpwm_if.sv
// rtl/m_wb_ledpwm_if.sv - Wishbone classic slave bundle for the LED PWM block
interface m_wb_ledpwm_if;
   logic        CYC_I;
   logic        STB_I;
   logic        WE_I;
   logic [1:0]  ADR_I;
   logic [3:0]  SEL_I;
   logic [31:0] DAT_I;
   logic [31:0] DAT_O;
   logic        ACK_O;

   modport master (output CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
                   input  DAT_O, ACK_O);
   modport slave  (input  CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
                   output DAT_O, ACK_O);
endinterface

// File: rtl/m_wb_ledpwm_pwmgen.sv
// rtl/m_wb_ledpwm_pwmgen.sv - prescaler plus free-running PWM counter with wrap pulse
module m_pwmgen #(
   parameter int PWMBITS      = 8,
   parameter int PRESCALEBITS = 16
) (
   input  logic                    CLK_I,
   input  logic                    RST_I,
   input  logic [PRESCALEBITS-1:0] prescale,
   input  logic                    prescale_clr,
   output logic [PWMBITS-1:0]      pwmcnt,
   output logic                    tick
);

   logic [PRESCALEBITS-1:0] presc;

   // A PRESCALE write restarts the prescaler phase; pwmcnt keeps its value.
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         presc  <= '0;
         pwmcnt <= '0;
         tick   <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (prescale_clr) begin
            presc <= '0;
         end else if (presc == prescale) begin
            presc  <= '0;
            pwmcnt <= pwmcnt + 1'b1;
            tick   <= (pwmcnt == {PWMBITS{1'b1}});
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

endmodule

// File: rtl/m_wb_ledpwm.sv
// rtl/m_wb_ledpwm.sv - Wishbone LED latch with per-LED PWM dimming
module m_wb_ledpwm
   import m_wb_ledpwm_pkg::*;
#(
   parameter int NLED         = 4,
   parameter int PWMBITS      = 8,
   parameter int PRESCALEBITS = 16
) (
   input  logic            CLK_I,
   input  logic            RST_I,
   m_wb_ledpwm_if.slave    wb,
   output logic [NLED-1:0] led_o,
   output logic            pwm_tick_o
);

   logic        accept;
   logic        wr;
   logic        prescale_clr;
   logic        pwm_on;
   logic [31:0] out_r, pwmen_r, duty_r, prescale_r;
   logic [31:0] m_out, m_pwmen, m_duty, m_prescale;
   logic [31:0] rd_mux;
   logic [PWMBITS-1:0] pwmcnt;

   assign accept       = wb.CYC_I & wb.STB_I & ~wb.ACK_O;
   assign wr           = accept & wb.WE_I;
   assign prescale_clr = wr & (wb.ADR_I == A_PRESCALE);

   // Masks are width-limited, so register bits above each width stay at their reset 0.
   always_comb begin
      m_out      = sel_mask(wb.SEL_I, NLED);
      m_pwmen    = sel_mask(wb.SEL_I, NLED);
      m_duty     = sel_mask(wb.SEL_I, PWMBITS);
      m_prescale = sel_mask(wb.SEL_I, PRESCALEBITS);
   end

   always_comb begin
      rd_mux = '0;
      case (wb.ADR_I)
         A_OUT:      rd_mux = out_r;
         A_PWMEN:    rd_mux = pwmen_r;
         A_DUTY:     rd_mux = duty_r;
         A_PRESCALE: rd_mux = prescale_r;
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         wb.ACK_O   <= 1'b0;
         wb.DAT_O   <= '0;
         out_r      <= '0;
         pwmen_r    <= '0;
         duty_r     <= '0;
         prescale_r <= '0;
      end else begin
         wb.ACK_O <= accept;
         if (accept)
            wb.DAT_O <= rd_mux;
         if (wr && wb.ADR_I == A_OUT)
            out_r <= (out_r & ~m_out) | (wb.DAT_I & m_out);
         if (wr && wb.ADR_I == A_PWMEN)
            pwmen_r <= (pwmen_r & ~m_pwmen) | (wb.DAT_I & m_pwmen);
         if (wr && wb.ADR_I == A_DUTY)
            duty_r <= (duty_r & ~m_duty) | (wb.DAT_I & m_duty);
         if (wr && wb.ADR_I == A_PRESCALE)
            prescale_r <= (prescale_r & ~m_prescale) | (wb.DAT_I & m_prescale);
      end
   end

   m_pwmgen #(
      .PWMBITS      (PWMBITS),
      .PRESCALEBITS (PRESCALEBITS)
   ) u_pwmgen (
      .CLK_I        (CLK_I),
      .RST_I        (RST_I),
      .prescale     (prescale_r[PRESCALEBITS-1:0]),
      .prescale_clr (prescale_clr),
      .pwmcnt       (pwmcnt),
      .tick         (pwm_tick_o)
   );

   assign pwm_on = (pwmcnt < duty_r[PWMBITS-1:0]);

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I)
         led_o <= '0;
      else
         led_o <= (out_r[NLED-1:0] & ~pwmen_r[NLED-1:0])
                | (out_r[NLED-1:0] & pwmen_r[NLED-1:0] & {NLED{pwm_on}});
   end

endmodule

// File: tb/tb_m_wb_ledpwm.sv
// tb/tb_m_wb_ledpwm.sv - directed self-checking bench for m_wb_ledpwm
module tb_m_wb_ledpwm;

   logic       CLK_I;
   logic       RST_I;
   logic [3:0] led_o;
   logic       pwm_tick_o;
   int         checks;
   int         failures;
   int         cyc;

   m_wb_ledpwm_if wb ();

   m_wb_ledpwm #(
      .NLED         (4),
      .PWMBITS      (8),
      .PRESCALEBITS (16)
   ) dut (
      .CLK_I      (CLK_I),
      .RST_I      (RST_I),
      .wb         (wb.slave),
      .led_o      (led_o),
      .pwm_tick_o (pwm_tick_o)
   );

   initial CLK_I = 1'b0;
   always #5 CLK_I = ~CLK_I;

   initial cyc = 0;
   always @(posedge CLK_I) cyc <= cyc + 1;

   typedef struct {
      logic        we;
      logic [1:0]  adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        chk_dat;
      logic [31:0] exp_dat;
      logic        chk_led;
      logic [3:0]  exp_led;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 one edge after the ACK edge.
   task automatic bus_xfer(input logic we, input logic [1:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, output logic [31:0] rdata);
      int n;
      wb.CYC_I = 1'b1;
      wb.STB_I = 1'b1;
      wb.WE_I  = we;
      wb.ADR_I = adr;
      wb.SEL_I = sel;
      wb.DAT_I = dat;
      n = 0;
      do begin
         @(posedge CLK_I); #1;
         n++;
      end while (!wb.ACK_O && n < 8);
      check("ack_latency", n, 1);
      rdata = wb.DAT_O;
      wb.CYC_I = 1'b0;
      wb.STB_I = 1'b0;
      wb.WE_I  = 1'b0;
      @(posedge CLK_I); #1;
   endtask

   task automatic wait_tick(output int t);
      int n;
      n = 0;
      do begin
         @(posedge CLK_I); #1;
         n++;
      end while (!pwm_tick_o && n < 3000);
      check("tick_seen", {31'd0, pwm_tick_o}, 32'd1);
      t = cyc;
   endtask

   initial begin
      logic [31:0] rd;
      int t0, t1, t2, hi_cnt, tick_cnt, tick_at, bad_hi;

      checks   = 0;
      failures = 0;

      vecs[0]  = '{1'b0, 2'd0, 4'hF, 32'h0,         1'b1, 32'h0,        1'b1, 4'h0};
      vecs[1]  = '{1'b0, 2'd1, 4'hF, 32'h0,         1'b1, 32'h0,        1'b0, 4'h0};
      vecs[2]  = '{1'b0, 2'd2, 4'hF, 32'h0,         1'b1, 32'h0,        1'b0, 4'h0};
      vecs[3]  = '{1'b0, 2'd3, 4'hF, 32'h0,         1'b1, 32'h0,        1'b0, 4'h0};
      vecs[4]  = '{1'b1, 2'd0, 4'h1, 32'h5,         1'b0, 32'h0,        1'b1, 4'h5};
      vecs[5]  = '{1'b0, 2'd0, 4'hF, 32'h0,         1'b1, 32'h5,        1'b0, 4'h0};
      vecs[6]  = '{1'b1, 2'd2, 4'h2, 32'hFFFF_FFFF, 1'b0, 32'h0,        1'b0, 4'h0};
      vecs[7]  = '{1'b0, 2'd2, 4'hF, 32'h0,         1'b1, 32'h0,        1'b0, 4'h0};
      vecs[8]  = '{1'b1, 2'd2, 4'h1, 32'hFFFF_FFFF, 1'b0, 32'h0,        1'b0, 4'h0};
      vecs[9]  = '{1'b0, 2'd2, 4'hF, 32'h0,         1'b1, 32'hFF,       1'b0, 4'h0};
      vecs[10] = '{1'b1, 2'd0, 4'hF, 32'hFFFF_FFF0, 1'b0, 32'h0,        1'b1, 4'h0};
      vecs[11] = '{1'b1, 2'd0, 4'h2, 32'h0000_000A, 1'b0, 32'h0,        1'b1, 4'h0};
      vecs[12] = '{1'b1, 2'd3, 4'hF, 32'h1234_5678, 1'b0, 32'h0,        1'b0, 4'h0};
      vecs[13] = '{1'b0, 2'd3, 4'hF, 32'h0,         1'b1, 32'h5678,     1'b0, 4'h0};
      vecs[14] = '{1'b1, 2'd1, 4'h1, 32'hAB,        1'b0, 32'h0,        1'b0, 4'h0};
      vecs[15] = '{1'b0, 2'd1, 4'hF, 32'h0,         1'b1, 32'hB,        1'b0, 4'h0};

      wb.CYC_I = 1'b0;
      wb.STB_I = 1'b0;
      wb.WE_I  = 1'b0;
      wb.ADR_I = 2'd0;
      wb.SEL_I = 4'h0;
      wb.DAT_I = 32'h0;
      RST_I    = 1'b0;
      repeat (3) @(posedge CLK_I);
      #1;
      check("rst_ack",  {31'd0, wb.ACK_O}, 32'd0);
      check("rst_dat",  wb.DAT_O, 32'd0);
      check("rst_led",  {28'd0, led_o}, 32'd0);
      check("rst_tick", {31'd0, pwm_tick_o}, 32'd0);
      RST_I = 1'b1;
      @(posedge CLK_I); #1;

      for (int i = 0; i < 16; i++) begin
         bus_xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, rd);
         if (vecs[i].chk_dat) check($sformatf("vec%0d_dat", i), rd, vecs[i].exp_dat);
         if (vecs[i].chk_led) check($sformatf("vec%0d_led", i), {28'd0, led_o}, {28'd0, vecs[i].exp_led});
      end

      // Static LEDs: OUT=F with PWMEN cleared.
      bus_xfer(1'b1, 2'd0, 4'h1, 32'hF, rd);
      bus_xfer(1'b1, 2'd1, 4'h1, 32'h0, rd);
      check("static_led", {28'd0, led_o}, 32'hF);

      // PWM on LED0, duty 64/256, prescale 0.
      bus_xfer(1'b1, 2'd3, 4'hF, 32'h0, rd);
      bus_xfer(1'b1, 2'd2, 4'h1, 32'd64, rd);
      bus_xfer(1'b1, 2'd1, 4'h1, 32'h1, rd);
      bus_xfer(1'b1, 2'd0, 4'h1, 32'hF, rd);
      wait_tick(t0);
      hi_cnt = 0; tick_cnt = 0; tick_at = 0; bad_hi = 0;
      for (int i = 0; i < 256; i++) begin
         @(posedge CLK_I); #1;
         if (led_o[0]) hi_cnt++;
         if (led_o[3:1] != 3'b111) bad_hi++;
         if (pwm_tick_o) begin tick_cnt++; tick_at = cyc; end
      end
      check("pwm_duty64_on", hi_cnt, 64);
      check("pwm_static_hi", bad_hi, 0);
      check("pwm_tick_cnt", tick_cnt, 1);
      check("pwm_period256", tick_at - t0, 256);

      // Prescale 3: PWM period 1024; rewrite mid-count shifts the phase by 2.
      bus_xfer(1'b1, 2'd3, 4'hF, 32'd3, rd);
      wait_tick(t0);
      wait_tick(t1);
      check("pwm_period1024", t1 - t0, 1024);
      repeat (41) begin @(posedge CLK_I); #1; end
      bus_xfer(1'b1, 2'd3, 4'hF, 32'd3, rd);
      wait_tick(t2);
      check("presc_restart", t2 - t1, 1026);

      // STB held high: ACK 0,1,0,1; async reset during the ACK cycle.
      wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = 1'b0; wb.ADR_I = 2'd0; wb.SEL_I = 4'hF;
      check("hold_ack0", {31'd0, wb.ACK_O}, 32'd0);
      @(posedge CLK_I); #1; check("hold_ack1", {31'd0, wb.ACK_O}, 32'd1);
      @(posedge CLK_I); #1; check("hold_ack2", {31'd0, wb.ACK_O}, 32'd0);
      @(posedge CLK_I); #1; check("hold_ack3", {31'd0, wb.ACK_O}, 32'd1);
      check("hold_dat", wb.DAT_O, 32'hF);
      #1 RST_I = 1'b0;
      #1;
      check("arst_ack", {31'd0, wb.ACK_O}, 32'd0);
      check("arst_dat", wb.DAT_O, 32'd0);
      check("arst_led", {28'd0, led_o}, 32'd0);
      check("arst_tick", {31'd0, pwm_tick_o}, 32'd0);
      wb.CYC_I = 1'b0; wb.STB_I = 1'b0;
      @(posedge CLK_I); #1;
      RST_I = 1'b1;
      @(posedge CLK_I); #1;
      for (int a = 0; a < 4; a++) begin
         bus_xfer(1'b0, a[1:0], 4'hF, 32'h0, rd);
         check($sformatf("arst_reg%0d", a), rd, 32'd0);
      end

      // STB without CYC is never acknowledged.
      wb.CYC_I = 1'b0; wb.STB_I = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK_I); #1;
         check("nocyc_ack", {31'd0, wb.ACK_O}, 32'd0);
      end
      wb.STB_I = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/m_wb_ledpwm.md
Name: m_wb_ledpwm

Overview:
Parametrised Wishbone classic slave that drives NLED board LED outputs. It generalises the single-address, three-bit LED latch into four readable and writable registers: output data, per-LED PWM enable, shared PWM duty, and prescaler. A free-running prescaled PWM generator dims any LED whose PWM bit is set. It sits on the midgetv core Wishbone bus in the board top level, and its registered ACK replaces the ad-hoc one-cycle STB-to-ACK flop.

Parameters:
NLED, 4, number of LED outputs (1..32).
PWMBITS, 8, width of the PWM counter and DUTY register (1..16).
PRESCALEBITS, 16, width of the prescaler counter and PRESCALE register (1..32).

Ports:
CLK_I  in  1  single clock; all state changes on its rising edge.
RST_I  in  1  reset, asynchronous and active-low; clears all state.
CYC_I  in  1  Wishbone cycle.
STB_I  in  1  Wishbone strobe; already qualified by the address decoder for this slave.
WE_I  in  1  write enable.
ADR_I  in  2  register select (bus address bits 3:2).
SEL_I  in  4  byte enables.
DAT_I  in  32  write data.
DAT_O  out  32  read data, registered.
ACK_O  out  1  acknowledge, registered.
led_o  out  NLED  LED drive, registered.
pwm_tick_o  out  1  one-cycle pulse when the PWM counter wraps to 0 (debug/testing).

Behaviour:
- Reset (RST_I=0, asynchronous) clears every register, counter and output to 0: OUT, PWMEN, DUTY, PRESCALE, prescaler, pwmcnt, ACK_O, DAT_O, led_o and pwm_tick_o.
- Register map:
  - ADR 0: OUT[NLED-1:0].
  - ADR 1: PWMEN[NLED-1:0].
  - ADR 2: DUTY[PWMBITS-1:0].
  - ADR 3: PRESCALE[PRESCALEBITS-1:0].
  - Bits above each register's width read as 0 and ignore writes.
- Handshake:
  - A transfer is accepted when CYC_I & STB_I & ~ACK_O.
  - ACK_O is set at the next edge and held exactly one cycle. Latency is one cycle, and there are no wait states beyond that.
  - If the master keeps STB_I high through the ACK cycle, ACK_O drops for one cycle and then accepts again. The rule is ACK_O <= CYC_I & STB_I & ~ACK_O.
- Write:
  - Committed at the same edge that sets ACK_O.
  - Byte lane k (DAT_I[8k+7:8k]) is written only if SEL_I[k]=1, and only for bits that exist in the register.
- Read:
  - DAT_O is loaded at the accepting edge with the zero-extended register value and is valid while ACK_O=1.
  - DAT_O keeps its value otherwise; it is not cleared after ACK.
- Prescaler:
  - Counts 0..PRESCALE. On reaching PRESCALE it wraps to 0 and issues an internal tick.
  - PRESCALE=0 gives a tick every cycle.
  - A write to PRESCALE also clears the prescaler to 0 in the same edge.
- PWM counter (pwmcnt):
  - Increments on each tick and wraps from 2^PWMBITS-1 to 0.
  - pwm_tick_o=1 for the single cycle following the edge at which pwmcnt wrapped to 0.
- LED output, registered and updated every cycle:
  - led_o[i] <= PWMEN[i] ? (OUT[i] & (pwmcnt < DUTY)) : OUT[i].
  - DUTY=0 gives always off.
  - DUTY=2^PWMBITS-1 gives on for (2^PWMBITS-1)/2^PWMBITS of the time.
  - Static (non-PWM) LEDs reflect a write to OUT one cycle after the write edge, i.e. two cycles after STB_I is first seen.
- Simultaneous events:
  - A write to DUTY takes effect on the comparison in the cycle after the write edge. pwmcnt is not reset.
  - A write to PWMEN or OUT has the same one-cycle latency.
- Reset mid-transfer: ACK_O clears immediately, the pending write is lost, and the master must restart the cycle.
- CYC_I=0 with STB_I=1: not accepted, no ACK.

Decomposition:
- Package m_wb_ledpwm_pkg holds:
  - register index constants A_OUT=0, A_PWMEN=1, A_DUTY=2, A_PRESCALE=3;
  - a byte-lane mask helper function (SEL to bit mask, truncated to register width).
- One sub-module, m_pwmgen, contains the prescaler, pwmcnt and pwm_tick_o.
  - Inputs: PRESCALE, prescale_clr.
  - Outputs: pwmcnt, tick.
- The bus interface, registers and LED compare stay in the top of the block.

Test Plan:
- Reset then read ADR 0..3 -> each DAT_O=0; ACK_O high exactly 1 cycle after STB_I; led_o=0.
- Write OUT=0x5 with SEL=0001, PWMEN=0 -> led_o=4'b0101 two cycles after STB_I; read-back of ADR 0 gives 0x00000005.
- Write PRESCALE=0, DUTY=64, PWMEN=0x1, OUT=0xF -> led_o[0] high for exactly 64 of every 256 cycles; led_o[3:1] constant 1; pwm_tick_o period 256.
- Write PRESCALE=3, then again mid-count -> prescaler restarts at 0; tick period becomes 4 cycles; PWM period 1024.
- Write DAT_I=0xFFFFFFFF to DUTY with SEL=0010 -> DUTY unchanged (PWMBITS=8); with SEL=0001 -> DUTY=0xFF; read returns 0x000000FF.
- Hold STB_I high for 4 cycles -> ACK_O pattern 0,1,0,1; assert RST_I low during an ACK cycle -> ACK_O and all registers 0 immediately.
